// File: rtl/bank_biu_wr_sched.sv
// AXI3 write-path scheduler: gates AW on outstanding/queue/ID-busy limits, releases
// W in AW order, retires B per set/way, flags AR hazards and handles flush/drain.
module bank_biu_wr_sched #(
  parameter int ID_WIDTH = 8,
  parameter int MAX_OUTS = 8,
  parameter int WQ_DEPTH = 4,
  localparam int CW = $clog2(MAX_OUTS + 1),
  localparam int PW = $clog2(WQ_DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                aw_valid_i,
  input  logic [5:0]          aw_id_i,
  output logic                aw_ready_o,
  output logic                axi_awvalid_o,
  input  logic                axi_awready_i,
  input  logic                sc_valid_i,
  input  logic [5:0]          sc_set_way_i,
  output logic                sc_ready_o,
  output logic                axi_wvalid_o,
  input  logic                axi_wready_i,
  input  logic                axi_bvalid_i,
  input  logic [ID_WIDTH-1:0] axi_bid_i,
  input  logic [1:0]          axi_bresp_i,
  output logic                axi_bready_o,
  input  logic [5:0]          ar_set_way_i,
  output logic                ar_hazard_o,
  input  logic                flush_req_i,
  output logic                flush_done_o,
  output logic [CW-1:0]       outs_cnt_o,
  output logic                err_o,
  output logic [1:0]          err_code_o,
  output logic [5:0]          err_id_o,
  input  logic                err_clr_i
);
  typedef enum logic [1:0] {RUN, DRAIN, FLUSHED} state_t;

  state_t        state, state_nxt;
  logic [63:0]   busy, busy_nxt;
  logic [CW-1:0] outs, outs_nxt;
  logic [5:0]    wq [WQ_DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr, rd_ptr_nxt;
  logic          live;
  logic          wq_empty, wq_full, aw_ok, aw_fire, w_fire, b_fire, b_hit;
  logic [5:0]    wq_head, bsw;
  logic          new_err;
  logic [1:0]    new_code;
  logic [5:0]    new_id;
  logic          unused_bid;

  assign unused_bid = ^axi_bid_i[ID_WIDTH-1:6];

  assign wq_empty = (wr_ptr == rd_ptr);
  assign wq_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign wq_head  = wq[rd_ptr[PW-1:0]];

  // live gates the bus-facing handshakes so everything reads 0 while in reset
  assign aw_ok         = live && (state == RUN) && (int'(outs) < MAX_OUTS) && !wq_full && !busy[aw_id_i];
  assign axi_awvalid_o = aw_valid_i & aw_ok;
  assign aw_fire       = axi_awvalid_o & axi_awready_i;
  assign aw_ready_o    = aw_fire;

  assign axi_wvalid_o = sc_valid_i & ~wq_empty;
  assign sc_ready_o   = axi_wready_i & ~wq_empty;
  assign w_fire       = axi_wvalid_o & axi_wready_i;

  assign axi_bready_o = live;
  assign bsw          = axi_bid_i[5:0];
  assign b_fire       = axi_bvalid_i & live;
  assign b_hit        = b_fire & busy[bsw];

  assign ar_hazard_o  = busy[ar_set_way_i];
  assign flush_done_o = (state == FLUSHED);
  assign outs_cnt_o   = outs;

  always_comb begin
    busy_nxt = busy;
    if (aw_fire) busy_nxt[aw_id_i] = 1'b1;
    if (b_hit)   busy_nxt[bsw]     = 1'b0;
    outs_nxt   = outs + CW'(aw_fire) - CW'(b_hit);
    rd_ptr_nxt = rd_ptr + (PW+1)'(w_fire);
  end

  // W mismatch outranks a same-cycle B error
  always_comb begin
    new_err  = 1'b0;
    new_code = 2'b00;
    new_id   = 6'd0;
    if (b_fire && !busy[bsw]) begin
      new_err = 1'b1; new_code = 2'b10; new_id = bsw;
    end else if (b_hit && axi_bresp_i != 2'b00) begin
      new_err = 1'b1; new_code = 2'b01; new_id = bsw;
    end
    if (w_fire && sc_set_way_i != wq_head) begin
      new_err = 1'b1; new_code = 2'b11; new_id = sc_set_way_i;
    end
  end

  // drain completion looks at next-cycle counts so FLUSHED follows the last B directly
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush_req_i) state_nxt = DRAIN;
      DRAIN:   if (outs_nxt == '0 && wr_ptr == rd_ptr_nxt) state_nxt = FLUSHED;
      FLUSHED: if (!flush_req_i) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= RUN;
      busy   <= '0;
      outs   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      live   <= 1'b0;
      for (int i = 0; i < WQ_DEPTH; i++) wq[i] <= '0;
    end else begin
      state  <= state_nxt;
      busy   <= busy_nxt;
      outs   <= outs_nxt;
      rd_ptr <= rd_ptr_nxt;
      live   <= 1'b1;
      if (aw_fire) begin
        wq[wr_ptr[PW-1:0]] <= aw_id_i;
        wr_ptr             <= wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_o      <= 1'b0;
      err_code_o <= 2'b00;
      err_id_o   <= 6'd0;
    end else if (new_err && (!err_o || err_clr_i)) begin
      err_o      <= 1'b1;
      err_code_o <= new_code;
      err_id_o   <= new_id;
    end else if (err_clr_i) begin
      err_o      <= 1'b0;
      err_code_o <= 2'b00;
      err_id_o   <= 6'd0;
    end
  end
endmodule

// File: tb/tb_bank_biu_wr_sched.sv
// Scenario bench for bank_biu_wr_sched; W order and outstanding counts tracked in queues.
module tb_bank_biu_wr_sched;
  logic       clk = 0, rst_n = 0;
  logic       aw_valid = 0, awready = 0, sc_valid = 0, wready = 0, bvalid = 0;
  logic [5:0] aw_id = 0, sc_sw = 0, ar_sw = 0;
  logic [7:0] bid = 0;
  logic [1:0] bresp = 0;
  logic       flush_req = 0, err_clr = 0;
  logic       aw_ready, awvalid, sc_ready, wvalid, bready, hazard, flush_done, err;
  logic [3:0] outs;
  logic [1:0] err_code;
  logic [5:0] err_id;
  int tests = 0, fails = 0;
  int wexp[$];
  int outs_exp[$];

  bank_biu_wr_sched #(.ID_WIDTH(8), .MAX_OUTS(8), .WQ_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .aw_valid_i(aw_valid), .aw_id_i(aw_id), .aw_ready_o(aw_ready),
    .axi_awvalid_o(awvalid), .axi_awready_i(awready),
    .sc_valid_i(sc_valid), .sc_set_way_i(sc_sw), .sc_ready_o(sc_ready),
    .axi_wvalid_o(wvalid), .axi_wready_i(wready),
    .axi_bvalid_i(bvalid), .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bready_o(bready),
    .ar_set_way_i(ar_sw), .ar_hazard_o(hazard),
    .flush_req_i(flush_req), .flush_done_o(flush_done), .outs_cnt_o(outs),
    .err_o(err), .err_code_o(err_code), .err_id_o(err_id), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    aw_valid = 1; aw_id = 1; sc_valid = 1; wready = 1; awready = 1; #1;
    tests++; if ({awvalid, aw_ready, wvalid, sc_ready, bready, hazard, flush_done, err} !== 8'b0) begin fails++; $display("FAIL reset_flags got %b want 0", {awvalid, aw_ready, wvalid, sc_ready, bready, hazard, flush_done, err}); end
    tests++; if ({outs, err_code, err_id} !== 12'b0) begin fails++; $display("FAIL reset_regs got %h want 0", {outs, err_code, err_id}); end
    aw_valid = 0; sc_valid = 0;
    tick; rst_n = 1; tick;
    tests++; if (bready !== 1'b1) begin fails++; $display("FAIL bready_after_reset got %b want 1", bready); end
  endtask

  task automatic test_single;
    aw_valid = 1; aw_id = 5; ar_sw = 5; #1;
    tests++; if ({awvalid, aw_ready, wvalid} !== 3'b110) begin fails++; $display("FAIL single_aw got %b want 110", {awvalid, aw_ready, wvalid}); end
    tests++; if (hazard !== 1'b0) begin fails++; $display("FAIL single_haz_pre got %b want 0", hazard); end
    tick; aw_valid = 0;
    tests++; if (outs !== 4'd1 || hazard !== 1'b1) begin fails++; $display("FAIL single_n1 got outs %0d haz %b want 1 1", outs, hazard); end
    sc_valid = 1; sc_sw = 5; #1;
    tests++; if ({wvalid, sc_ready} !== 2'b11) begin fails++; $display("FAIL single_w got %b want 11", {wvalid, sc_ready}); end
    tick; sc_valid = 0;
    tick;
    bvalid = 1; bid = 5; bresp = 0; #1;
    tests++; if (outs !== 4'd1 || hazard !== 1'b1) begin fails++; $display("FAIL single_n3 got outs %0d haz %b want 1 1", outs, hazard); end
    tick; bvalid = 0;
    tests++; if (outs !== 4'd0 || hazard !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL single_done got outs %0d haz %b err %b want 0 0 0", outs, hazard, err); end
  endtask

  task automatic test_back_to_back;
    logic exp_aw;
    for (int k = 0; k <= 8; k++) begin
      aw_valid = 1; aw_id = 6'(k);
      if (k > 0) begin sc_valid = 1; sc_sw = 6'(wexp.pop_front()); end
      exp_aw = (k < 8);
      if (exp_aw) begin wexp.push_back(k); outs_exp.push_back(k + 1); end
      else outs_exp.push_back(8);
      #1;
      tests++; if (awvalid !== exp_aw || aw_ready !== exp_aw) begin fails++; $display("FAIL b2b_aw%0d got %b%b want %b", k, awvalid, aw_ready, exp_aw); end
      tick;
      begin
        int e = outs_exp.pop_front();
        tests++; if (outs !== 4'(e)) begin fails++; $display("FAIL b2b_outs%0d got %0d want %0d", k, outs, e); end
      end
    end
    sc_valid = 0; #1;
    tests++; if (awvalid !== 1'b0) begin fails++; $display("FAIL b2b_hold got %b want 0", awvalid); end
    tick;
    bvalid = 1; bid = 0; #1;
    tests++; if (awvalid !== 1'b0) begin fails++; $display("FAIL b2b_bsame got %b want 0", awvalid); end
    tick; bvalid = 0; #1;
    tests++; if (awvalid !== 1'b1 || outs !== 4'd7) begin fails++; $display("FAIL b2b_release got aw %b outs %0d want 1 7", awvalid, outs); end
    tick; aw_valid = 0;
    tests++; if (outs !== 4'd8) begin fails++; $display("FAIL b2b_refill got %0d want 8", outs); end
    sc_valid = 1; sc_sw = 8; tick; sc_valid = 0;
    for (int k = 1; k <= 8; k++) begin bvalid = 1; bid = 8'(k); tick; end
    bvalid = 0;
    tests++; if (outs !== 4'd0 || err !== 1'b0) begin fails++; $display("FAIL b2b_drain got outs %0d err %b want 0 0", outs, err); end
  endtask

  task automatic test_hazard;
    aw_valid = 1; aw_id = 3; tick;
    awready = 0; sc_valid = 1; sc_sw = 3; ar_sw = 3; tick; sc_valid = 0; #1;
    tests++; if ({hazard, awvalid} !== 2'b10) begin fails++; $display("FAIL haz_block got %b want 10", {hazard, awvalid}); end
    bvalid = 1; bid = 3; #1;
    tests++; if ({hazard, awvalid} !== 2'b10) begin fails++; $display("FAIL haz_bcycle got %b want 10", {hazard, awvalid}); end
    tick; bvalid = 0; #1;
    tests++; if ({hazard, awvalid} !== 2'b01) begin fails++; $display("FAIL haz_release got %b want 01", {hazard, awvalid}); end
    aw_valid = 0; awready = 1;
  endtask

  task automatic test_w_mismatch;
    aw_valid = 1; aw_id = 2; tick; aw_valid = 0;
    sc_valid = 1; sc_sw = 7; #1;
    tests++; if (wvalid !== 1'b1) begin fails++; $display("FAIL mm_wvalid got %b want 1", wvalid); end
    tick; #1;
    tests++; if ({err, err_code, err_id} !== {1'b1, 2'b11, 6'd7}) begin fails++; $display("FAIL mm_err got %b/%b/%0d want 1/11/7", err, err_code, err_id); end
    tests++; if (wvalid !== 1'b0) begin fails++; $display("FAIL mm_pop got %b want 0", wvalid); end
    sc_valid = 0; bvalid = 1; bid = 9; tick;
    tests++; if ({err, err_code, err_id} !== {1'b1, 2'b11, 6'd7} || outs !== 4'd1) begin fails++; $display("FAIL mm_first_wins got %b/%b/%0d outs %0d want 1/11/7 1", err, err_code, err_id, outs); end
    bid = 2; tick; bvalid = 0;
    err_clr = 1; tick; err_clr = 0;
    tests++; if (err !== 1'b0 || outs !== 4'd0) begin fails++; $display("FAIL mm_clr got err %b outs %0d want 0 0", err, outs); end
  endtask

  task automatic test_bresp;
    aw_valid = 1; aw_id = 4; tick; aw_valid = 0;
    sc_valid = 1; sc_sw = 4; tick; sc_valid = 0;
    bvalid = 1; bid = 4; bresp = 2'b10; tick; bresp = 0;
    tests++; if ({err, err_code, err_id} !== {1'b1, 2'b01, 6'd4} || outs !== 4'd0) begin fails++; $display("FAIL bresp_err got %b/%b/%0d outs %0d want 1/01/4 0", err, err_code, err_id, outs); end
    bid = 1; err_clr = 1; tick; bvalid = 0; err_clr = 0;
    tests++; if ({err, err_code, err_id} !== {1'b1, 2'b10, 6'd1}) begin fails++; $display("FAIL clr_new_err got %b/%b/%0d want 1/10/1", err, err_code, err_id); end
    err_clr = 1; tick; err_clr = 0;
  endtask

  task automatic test_flush;
    aw_valid = 1; aw_id = 10; tick;
    aw_id = 11; sc_valid = 1; sc_sw = 10; tick;
    aw_id = 12; sc_sw = 11; tick;
    aw_valid = 0; sc_sw = 12; tick; sc_valid = 0;
    tests++; if (outs !== 4'd3) begin fails++; $display("FAIL flush_outs got %0d want 3", outs); end
    flush_req = 1; tick;
    aw_valid = 1; aw_id = 20; #1;
    tests++; if (awvalid !== 1'b0) begin fails++; $display("FAIL flush_aw_block got %b want 0", awvalid); end
    for (int k = 10; k <= 12; k++) begin
      tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL flush_early%0d got %b want 0", k, flush_done); end
      bvalid = 1; bid = 8'(k); tick;
    end
    bvalid = 0;
    tests++; if (flush_done !== 1'b1 || outs !== 4'd0 || awvalid !== 1'b0) begin fails++; $display("FAIL flush_done got done %b outs %0d aw %b want 1 0 0", flush_done, outs, awvalid); end
    tick;
    tests++; if (flush_done !== 1'b1) begin fails++; $display("FAIL flush_hold got %b want 1", flush_done); end
    flush_req = 0; awready = 0; #1;
    tests++; if (awvalid !== 1'b0) begin fails++; $display("FAIL flush_drop_same got %b want 0", awvalid); end
    tick;
    tests++; if (awvalid !== 1'b1 || flush_done !== 1'b0) begin fails++; $display("FAIL flush_resume got aw %b done %b want 1 0", awvalid, flush_done); end
    aw_valid = 0; awready = 1;
  endtask

  task automatic test_mid_reset;
    aw_valid = 1; aw_id = 30; ar_sw = 30; tick; aw_valid = 0;
    tests++; if (outs !== 4'd1 || hazard !== 1'b1) begin fails++; $display("FAIL mr_pre got outs %0d haz %b want 1 1", outs, hazard); end
    rst_n = 0; #1;
    tests++; if (outs !== 4'd0 || hazard !== 1'b0 || bready !== 1'b0) begin fails++; $display("FAIL mr_clear got outs %0d haz %b bready %b want 0 0 0", outs, hazard, bready); end
    tick; rst_n = 1; tick;
    sc_valid = 1; sc_sw = 30; #1;
    tests++; if (wvalid !== 1'b0) begin fails++; $display("FAIL mr_wq_empty got %b want 0", wvalid); end
    sc_valid = 0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_hazard;
    test_w_mismatch;
    test_bresp;
    test_flush;
    test_mid_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bank_biu_wr_sched.md
# bank_biu_wr_sched

Write-path scheduler that sits between the bank BIU request FIFO output and the AXI3 AW/W/B channels. It admits AW requests only when write resources allow, holds cache-side write data until its address has been accepted, and tracks outstanding writes per set/way ID until their B response returns. It also flags read-after-write hazards to the AR path, provides a flush/drain handshake, and captures write-side protocol errors.

## Interface
- ID_WIDTH, 8, AXI ID width; only bits [5:0] carry set/way.
- MAX_OUTS, 8, maximum writes awaiting B; 1..63.
- WQ_DEPTH, 4, AW-accepted/W-pending queue depth; power of 2, ≥2.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- aw_valid_i  in  1  upstream AW request valid.
- aw_id_i  in  6  upstream AW set/way.
- aw_ready_o  out  1  upstream AW accepted (= axi_awvalid_o & axi_awready_i).
- axi_awvalid_o  out  1  gated AW valid to bus.
- axi_awready_i  in  1  bus AW ready.
- sc_valid_i  in  1  write data valid from SC.
- sc_set_way_i  in  6  write data set/way.
- sc_ready_o  out  1  write data accepted.
- axi_wvalid_o  out  1  gated W valid to bus.
- axi_wready_i  in  1  bus W ready.
- axi_bvalid_i  in  1  B response valid.
- axi_bid_i  in  ID_WIDTH  B response ID.
- axi_bresp_i  in  2  B response code.
- axi_bready_o  out  1  B ready.
- ar_set_way_i  in  6  set/way of the pending AR at the FIFO head.
- ar_hazard_o  out  1  a write to ar_set_way_i is outstanding.
- flush_req_i  in  1  level request to drain all writes.
- flush_done_o  out  1  drain complete, held while flush_req_i is high.
- outs_cnt_o  out  $clog2(MAX_OUTS+1)  writes awaiting B.
- err_o  out  1  sticky error flag.
- err_code_o  out  2  01 bad bresp, 10 spurious B, 11 W ID mismatch.
- err_id_o  out  6  ID associated with the captured error.
- err_clr_i  in  1  clears the sticky error.

## Operation
- State: busy[63:0] bitmap, outstanding counter, WQ FIFO of 6-bit IDs, FSM {RUN, DRAIN, FLUSHED}, error registers.
- AW gate: aw_ok = (state==RUN) & (outs < MAX_OUTS) & ~wq_full & ~busy[aw_id_i]. axi_awvalid_o = aw_valid_i & aw_ok. All terms are combinational from registers and inputs.
- AW fire (axi_awvalid_o & axi_awready_i):
  - push aw_id_i into WQ;
  - set busy[aw_id_i];
  - outs +1.
- W gate: axi_wvalid_o = sc_valid_i & ~wq_empty. sc_ready_o = axi_wready_i & ~wq_empty.
- W fire pops the WQ. If sc_set_way_i != WQ head, capture error 11 with err_id_o = sc_set_way_i; the transfer still completes.
- axi_bready_o is 1 whenever out of reset.
- B fire with busy[bid[5:0]] set:
  - clear the busy bit;
  - outs −1;
  - if bresp != 00, capture error 01 with the ID.
- B fire with the busy bit clear: capture error 10. Counter and bitmap are unchanged; the counter never underflows.
- Same-cycle AW fire and B fire: counter net 0. The same ID cannot occur in both, because AW is blocked while busy.
- ar_hazard_o = busy[ar_set_way_i], combinational.
- Errors:
  - first error wins while err_o=1;
  - err_clr_i clears err_o next cycle;
  - if err_clr_i and a new error occur in the same cycle, the new error is captured.
- FSM:
  - RUN → DRAIN when flush_req_i=1.
  - DRAIN: AW is blocked. W and B proceed. Go to FLUSHED when outs==0 and wq_empty.
  - FLUSHED: flush_done_o=1 and AW is blocked. Go to RUN when flush_req_i=0.
  - If flush_req_i drops while in DRAIN, complete the drain to FLUSHED, then return to RUN.

## Timing
- Reset values: all of the following are 0 —
  - axi_awvalid_o, aw_ready_o, axi_wvalid_o, sc_ready_o, ar_hazard_o, flush_done_o, outs_cnt_o, err_o, err_code_o, err_id_o;
  - axi_bready_o;
  - busy, the WQ, and the FSM (which resets to RUN).
- Reset applied mid-operation discards all tracking immediately.
- AW fire at cycle N: the WQ entry, busy bit and outs are visible at N+1. The earliest W for that write is N+1; W never fires in the same cycle as its own AW.
- B fire at cycle N: busy clear and outs decrement are visible at N+1. A blocked AW/AR for that ID is released at N+1.
- WQ full with simultaneous pop: AW stays blocked that cycle (full is evaluated on registered state).
- FLUSHED is reached one cycle after the last B when the WQ is already empty.

## Test plan
- Single write, ID 5: AW at N, W at N+1, B at N+3 → busy[5] high N+1..N+3, outs 0→1→0, no error.
- 9 back-to-back AWs with IDs 0..8, MAX_OUTS=8, no B → 8 accepted, 9th held with axi_awvalid_o=0; one B for ID 0 → 9th fires the next cycle.
- AW for ID 3 pending while busy[3]; ar_set_way_i=3 → ar_hazard_o=1 and AW blocked until B id 3, both released the cycle after.
- W with set_way 7 while the WQ head is 2 → err_o=1, code 11, err_id 7, pop occurs; B id 9 with nothing outstanding → first error retained.
- B id 4 with bresp=10 → err 01/id 4; err_clr_i together with a spurious B id 1 → err code 10/id 1.
- flush_req_i with 3 outstanding → AW blocked immediately; flush_done_o rises the cycle after the 3rd B; drop flush_req_i → AW resumes the next cycle.
